// File: rtl/alu_div_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state encoding,
// FLAGS bit positions (same layout as the combinational ALU) and the
// AAM flag generation helper.
package alu_div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE  = 2'd0,
        DIV_CHECK = 2'd1,
        DIV_RUN   = 2'd2,
        DIV_FIX   = 2'd3
    } div_state_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_P = 2;
    localparam int FLAG_A = 4;
    localparam int FLAG_Z = 6;
    localparam int FLAG_S = 7;
    localparam int FLAG_O = 11;

    // AAM: S/Z/P follow the new AL, O/A/C are cleared, the rest pass through.
    function automatic logic [11:0] aam_flags(input logic [11:0] f, input logic [7:0] al);
        logic [11:0] r;
        r         = f;
        r[FLAG_S] = al[7];
        r[FLAG_Z] = (al == 8'h00);
        r[FLAG_P] = ~^al;
        r[FLAG_O] = 1'b0;
        r[FLAG_A] = 1'b0;
        r[FLAG_C] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/alu_div_step.sv
// One restoring divide step: compare the 17-bit shifted partial remainder
// against the divisor and subtract when it fits. Combinational, 0 cycles.
// No handshake; reused by the control FSM once per RUN cycle.
// Ports: prem_in (17b shifted partial remainder), divisor (16b),
//        prem_out (16b new partial remainder), qbit (quotient bit).
module alu_div_step (
    input  logic [16:0] prem_in,
    input  logic [15:0] divisor,
    output logic [15:0] prem_out,
    output logic        qbit
);

    logic [15:0] diff;

    always_comb begin
        qbit = (prem_in >= {1'b0, divisor});
        // When the subtraction happens the result is below the divisor,
        // so 16 bits are enough and the carry-out is never needed.
        diff     = prem_in[15:0] - divisor;
        prem_out = qbit ? diff : prem_in[15:0];
    end

endmodule

// File: rtl/alu_div.sv
// DIV/IDIV (8/16-bit) and AAM divider with 8086 divide-error detection.
// Latency: N+2 cycles from accepting edge to done (N=8 or 16); 1 cycle on an early error.
// start is only taken while idle and not in the done cycle; requests while busy are dropped.
// Ports: clock/reset_n; start, isize, signd, aam, op1 (dividend), op2 (divisor),
//        flags (FLAGS in); busy, done, div_err, quot, rem, flags_o (results, valid with done).
module alu_div
    import alu_div_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        isize,
    input  logic        signd,
    input  logic        aam,
    input  logic [31:0] op1,
    input  logic [15:0] op2,
    input  logic [11:0] flags,
    output logic        busy,
    output logic        done,
    output logic        div_err,
    output logic [15:0] quot,
    output logic [15:0] rem,
    output logic [11:0] flags_o
);

    div_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        isize_q, isize_d, signd_q, signd_d, aam_q, aam_d;
    logic [31:0] op1_q, op1_d;
    logic [15:0] op2_q, op2_d;
    logic [11:0] flags_q, flags_d;
    logic [15:0] pr_q, pr_d;      // partial remainder
    logic [15:0] lo_q, lo_d;      // dividend low half shifting out, quotient bits shifting in
    logic [15:0] dvs_q, dvs_d;    // divisor magnitude
    logic        qneg_q, qneg_d, rneg_q, rneg_d;
    logic        done_q, done_d, div_err_q, div_err_d;
    logic [15:0] quot_q, quot_d, rem_q, rem_d;
    logic [11:0] flags_o_q, flags_o_d;

    logic        wide, dvd_neg, dvs_neg, chk_err, fix_err;
    logic [31:0] dvd_mag;
    logic [15:0] dvs_mag, hi_mag, lo_init, qmag;
    logic [15:0] step_prem;
    logic        step_qbit;

    alu_div_step u_step (
        .prem_in  ({pr_q, lo_q[15]}),
        .divisor  (dvs_q),
        .prem_out (step_prem),
        .qbit     (step_qbit)
    );

    // Operand magnitudes from the latched request. The 8-bit low half is
    // left-aligned so the next dividend bit is always lo_q[15].
    always_comb begin
        wide = isize_q & ~aam_q;
        if (aam_q) begin
            dvd_neg = 1'b0;
            dvs_neg = 1'b0;
            dvd_mag = {24'h0, op1_q[7:0]};
            dvs_mag = {8'h0, op2_q[7:0]};
        end else if (wide) begin
            dvd_neg = signd_q & op1_q[31];
            dvs_neg = signd_q & op2_q[15];
            dvd_mag = dvd_neg ? -op1_q : op1_q;
            dvs_mag = dvs_neg ? -op2_q : op2_q;
        end else begin
            dvd_neg = signd_q & op1_q[15];
            dvs_neg = signd_q & op2_q[7];
            dvd_mag = {16'h0, (dvd_neg ? -op1_q[15:0] : op1_q[15:0])};
            dvs_mag = {8'h0, (dvs_neg ? -op2_q[7:0] : op2_q[7:0])};
        end
        hi_mag  = wide ? dvd_mag[31:16] : {8'h0, dvd_mag[15:8]};
        lo_init = wide ? dvd_mag[15:0]  : {dvd_mag[7:0], 8'h0};
        // High half not below the divisor means the quotient cannot fit.
        chk_err = (dvs_mag == 16'h0) || (hi_mag >= dvs_mag);
        qmag    = wide ? lo_q : {8'h0, lo_q[7:0]};
        // Signed quotients trap above 2^(N-1)-1, including the most negative value.
        fix_err = signd_q && (qmag > (wide ? 16'h7FFF : 16'h007F));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        isize_d   = isize_q;
        signd_d   = signd_q;
        aam_d     = aam_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        flags_d   = flags_q;
        pr_d      = pr_q;
        lo_d      = lo_q;
        dvs_d     = dvs_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        done_d    = 1'b0;
        div_err_d = div_err_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        flags_o_d = flags_o_q;

        case (state_q)
            DIV_IDLE: begin
                // done_q blocks a start issued in the done cycle itself.
                if (start && !done_q) begin
                    isize_d = isize;
                    signd_d = signd;
                    aam_d   = aam;
                    op1_d   = op1;
                    op2_d   = op2;
                    flags_d = flags;
                    state_d = DIV_CHECK;
                end
            end
            DIV_CHECK: begin
                if (chk_err) begin
                    div_err_d = 1'b1;
                    done_d    = 1'b1;
                    flags_o_d = flags_q;
                    state_d   = DIV_IDLE;
                end else begin
                    pr_d    = hi_mag;
                    lo_d    = lo_init;
                    dvs_d   = dvs_mag;
                    qneg_d  = dvd_neg ^ dvs_neg;
                    rneg_d  = dvd_neg;
                    cnt_d   = wide ? 4'd15 : 4'd7;
                    state_d = DIV_RUN;
                end
            end
            DIV_RUN: begin
                pr_d  = step_prem;
                lo_d  = {lo_q[14:0], step_qbit};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                quot_d    = qneg_q ? -qmag : qmag;
                rem_d     = rneg_q ? -pr_q : pr_q;
                div_err_d = fix_err;
                flags_o_d = aam_q ? aam_flags(flags_q, pr_q[7:0]) : flags_q;
                done_d    = 1'b1;
                state_d   = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= 4'd0;
            isize_q   <= 1'b0;
            signd_q   <= 1'b0;
            aam_q     <= 1'b0;
            op1_q     <= 32'h0;
            op2_q     <= 16'h0;
            flags_q   <= 12'h0;
            pr_q      <= 16'h0;
            lo_q      <= 16'h0;
            dvs_q     <= 16'h0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            done_q    <= 1'b0;
            div_err_q <= 1'b0;
            quot_q    <= 16'h0;
            rem_q     <= 16'h0;
            flags_o_q <= 12'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            isize_q   <= isize_d;
            signd_q   <= signd_d;
            aam_q     <= aam_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            flags_q   <= flags_d;
            pr_q      <= pr_d;
            lo_q      <= lo_d;
            dvs_q     <= dvs_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            done_q    <= done_d;
            div_err_q <= div_err_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            flags_o_q <= flags_o_d;
        end
    end

    assign busy    = (state_q != DIV_IDLE);
    assign done    = done_q;
    assign div_err = div_err_q;
    assign quot    = quot_q;
    assign rem     = rem_q;
    assign flags_o = flags_o_q;

endmodule

// File: tb/tb_alu_div.sv
// Directed bench for alu_div: hand-computed quotients, remainders, flags,
// latencies, error cases, ignored starts and mid-operation reset.
module tb_alu_div;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        isize;
    logic        signd;
    logic        aam;
    logic [31:0] op1;
    logic [15:0] op2;
    logic [11:0] flags;
    logic        busy;
    logic        done;
    logic        div_err;
    logic [15:0] quot;
    logic [15:0] rem;
    logic [11:0] flags_o;

    int n_cmp;
    int n_bad;

    alu_div dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .isize   (isize),
        .signd   (signd),
        .aam     (aam),
        .op1     (op1),
        .op2     (op2),
        .flags   (flags),
        .busy    (busy),
        .done    (done),
        .div_err (div_err),
        .quot    (quot),
        .rem     (rem),
        .flags_o (flags_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one operation and return with the bench sitting in the done
    // cycle (#1 after its edge); lat counts edges from the accepting edge.
    task automatic do_op(input logic sz, input logic sg, input logic am,
                         input logic [31:0] a, input logic [15:0] b,
                         input logic [11:0] f, output int lat);
        repeat (2) @(negedge clock);
        isize = sz; signd = sg; aam = am; op1 = a; op2 = b; flags = f;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'h1);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clock);
            #1 lat++;
        end
        chk("busy_in_done", 32'(busy), 32'h0);
    endtask

    int lat;
    int ndone;
    int done_at;
    logic [15:0] q_seen;

    initial begin
        n_cmp = 0; n_bad = 0;
        reset_n = 1'b0; start = 1'b0; isize = 1'b0; signd = 1'b0; aam = 1'b0;
        op1 = 32'h0; op2 = 16'h0; flags = 12'h0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(div_err), 32'h0);
        chk("rst_quot", 32'(quot), 32'h0);
        chk("rst_rem", 32'(rem), 32'h0);
        chk("rst_flags", 32'(flags_o), 32'h0);
        @(negedge clock) reset_n = 1'b1;

        // DIV16 0x0001_0000 / 2
        do_op(1'b1, 1'b0, 1'b0, 32'h0001_0000, 16'h0002, 12'h000, lat);
        chk("div16_lat", 32'(lat), 32'd18);
        chk("div16_quot", 32'(quot), 32'h8000);
        chk("div16_rem", 32'(rem), 32'h0000);
        chk("div16_err", 32'(div_err), 32'h0);
        repeat (3) @(posedge clock);
        #1 chk("hold_quot", 32'(quot), 32'h8000);

        // DIV8 100 / 7, flags pass through
        do_op(1'b0, 1'b0, 1'b0, 32'h0000_0064, 16'h0007, 12'hA5A, lat);
        chk("div8_lat", 32'(lat), 32'd10);
        chk("div8_quot", 32'(quot), 32'h000E);
        chk("div8_rem", 32'(rem), 32'h0002);
        chk("div8_flags", 32'(flags_o), 32'hA5A);

        // IDIV8 -100 / 7
        do_op(1'b0, 1'b1, 1'b0, 32'h0000_FF9C, 16'h0007, 12'h000, lat);
        chk("idiv8_lat", 32'(lat), 32'd10);
        chk("idiv8_quot", 32'(quot), 32'hFFF2);
        chk("idiv8_rem", 32'(rem), 32'hFFFE);
        chk("idiv8_err", 32'(div_err), 32'h0);

        // IDIV16 -7 / 2
        do_op(1'b1, 1'b1, 1'b0, 32'hFFFF_FFF9, 16'h0002, 12'h000, lat);
        chk("idiv16_quot", 32'(quot), 32'hFFFD);
        chk("idiv16_rem", 32'(rem), 32'hFFFF);

        // IDIV16 -32768 / 1 traps in FIX
        do_op(1'b1, 1'b1, 1'b0, 32'hFFFF_8000, 16'h0001, 12'h000, lat);
        chk("idiv16_trap_lat", 32'(lat), 32'd18);
        chk("idiv16_trap_err", 32'(div_err), 32'h1);

        // IDIV8 -128 / 1 traps in FIX
        do_op(1'b0, 1'b1, 1'b0, 32'h0000_FF80, 16'h0001, 12'h000, lat);
        chk("idiv8_trap_lat", 32'(lat), 32'd10);
        chk("idiv8_trap_err", 32'(div_err), 32'h1);

        // DIV8 0x0200 / 2 overflows in CHECK
        do_op(1'b0, 1'b0, 1'b0, 32'h0000_0200, 16'h0002, 12'h000, lat);
        chk("div8_ovf_lat", 32'(lat), 32'd1);
        chk("div8_ovf_err", 32'(div_err), 32'h1);

        // DIV16 divide by zero
        do_op(1'b1, 1'b0, 1'b0, 32'h0000_1234, 16'h0000, 12'h000, lat);
        chk("div0_lat", 32'(lat), 32'd1);
        chk("div0_err", 32'(div_err), 32'h1);

        // AAM AL=0x3F / 10; AH, isize, signd ignored
        do_op(1'b1, 1'b1, 1'b1, 32'h0000_FF3F, 16'h000A, 12'hFFF, lat);
        chk("aam_lat", 32'(lat), 32'd10);
        chk("aam_err", 32'(div_err), 32'h0);
        chk("aam_quot", 32'(quot[7:0]), 32'h06);
        chk("aam_rem", 32'(rem[7:0]), 32'h03);
        chk("aam_flags", 32'(flags_o), 32'h72E);

        // Start held in the done cycle is not accepted
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        chk("start_in_done_busy", 32'(busy), 32'h0);

        // AAM by zero
        do_op(1'b0, 1'b0, 1'b1, 32'h0000_003F, 16'h0000, 12'h000, lat);
        chk("aam0_lat", 32'(lat), 32'd1);
        chk("aam0_err", 32'(div_err), 32'h1);

        // Start pulse during RUN is ignored: one done, original result
        repeat (2) @(negedge clock);
        isize = 1'b1; signd = 1'b0; aam = 1'b0; op1 = 32'h0001_0000; op2 = 16'h0002;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        ndone = 0; done_at = 0; q_seen = 16'h0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 5) begin
                op1 = 32'h0000_0064; op2 = 16'h0007; isize = 1'b0; start = 1'b1;
            end
            @(posedge clock);
            #1 start = 1'b0;
            if (done) begin
                ndone++;
                done_at = c;
                q_seen = quot;
            end
        end
        chk("busy_start_ndone", 32'(ndone), 32'd1);
        chk("busy_start_lat", 32'(done_at), 32'd18);
        chk("busy_start_quot", 32'(q_seen), 32'h8000);

        // Reset in the middle of RUN
        repeat (2) @(negedge clock);
        isize = 1'b1; signd = 1'b0; aam = 1'b0; op1 = 32'h0001_0000; op2 = 16'h0002;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (6) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_quot", 32'(quot), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        @(negedge clock) reset_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clock);
            #1 if (done) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        do_op(1'b0, 1'b0, 1'b0, 32'h0000_0064, 16'h0007, 12'h000, lat);
        chk("after_rst_lat", 32'(lat), 32'd10);
        chk("after_rst_quot", 32'(quot), 32'h000E);
        chk("after_rst_rem", 32'(rem), 32'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
